bp_lce_req_arbiter: RTL and testbench
=====================================

Name: bp_lce_req_arbiter

Overview:
- Shares one LCE request network port among num_lce_p LCE request handlers (e.g. I$ LCE and D$ LCE of one tile).
- Each requester gets a one-entry input buffer and its own outstanding-request credit counter.
- Buffered messages go to the shared outbound port in round-robin order, using the same ready->valid handshake the LCE request handlers use.

Parameters:
- num_lce_p, 2, number of requesting LCEs; must be >= 2.
- msg_width_p, 128, width of one packed bedrock LCE request message.
- credits_p, 8, maximum outstanding requests per requester; includes the buffered request.
- lg_num_lce_lp, BSG_SAFE_CLOG2(num_lce_p), localparam, grant index width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- lce_req_i  in  num_lce_p*msg_width_p  request messages; slice i belongs to requester i.
- lce_req_v_i  in  num_lce_p  per-requester valid; legal only while lce_req_ready_o[i]=1.
- lce_req_ready_o  out  num_lce_p  per-requester ready; depends on registered state only.
- req_complete_i  in  num_lce_p  per-requester credit return, one pulse per completed request.
- lce_req_o  out  msg_width_p  outbound message.
- lce_req_v_o  out  1  outbound valid.
- lce_req_ready_i  in  1  outbound network ready.
- lce_req_grant_o  out  lg_num_lce_lp  index of the requester whose message is on lce_req_o.
- credits_empty_o  out  num_lce_p  count_r[i]==0.
- underflow_o  out  1  sticky error flag.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk_i, reset_n_i).
- Reset:
  - All buffers are empty; all count_r are 0; rr pointer is 0; underflow_o is 0.
  - Output values during reset: lce_req_v_o=0, lce_req_ready_o=all ones, credits_empty_o=all ones, lce_req_grant_o=0, lce_req_o=0.
  - Reset asserted mid-operation discards buffered messages and outstanding counts immediately; no message is emitted afterwards.
- Input side:
  - lce_req_ready_o[i] = ~buf_v_r[i] & (count_r[i] < credits_p).
  - On lce_req_v_i[i], the message is captured into buf_r[i], buf_v_r[i] is set, and count_r[i] increments.
  - lce_req_v_i[i] asserted while ready is 0 is ignored: no capture, no count change.
- Arbitration:
  - The candidate set is all i with buf_v_r[i]=1.
  - Grant goes to the first candidate at or after rr_r, scanning upward and wrapping modulo num_lce_p.
  - Grant is purely combinational from registered state.
- Output side:
  - lce_req_v_o = lce_req_ready_i & |buf_v_r.
  - lce_req_o = buf_r[grant]; lce_req_grant_o = grant.
  - When lce_req_v_o=1: buf_v_r[grant] clears and rr_r <= grant+1, wrapping to 0 after num_lce_p-1.
  - With no send, rr_r holds its value.
- Latency: a message accepted at cycle t appears on lce_req_o no earlier than t+1.
- Throughput:
  - At most one message per cycle outbound.
  - At most one message per 2 cycles per requester, because ready drops while the buffer is full.
- Credit counter count_r[i], width BSG_WIDTH(credits_p):
  - Increments on input accept; decrements on req_complete_i[i].
  - Both in the same cycle: count is unchanged.
  - req_complete_i[i] while count_r[i]==0 and no same-cycle accept: count stays 0 and underflow_o sets; only reset clears it.
  - Dequeue does not change count_r; a request is counted from acceptance until its completion pulse.
- Boundaries:
  - All buffers empty: lce_req_v_o=0 regardless of lce_req_ready_i.
  - lce_req_ready_i=0: nothing is dequeued and rr_r holds.
  - count_r[i]==credits_p: ready_o[i]=0 until a completion arrives. A completion at cycle t raises ready at t+1.
- No FSM beyond the per-slot buffer valid bits, the rr pointer and the counters; implementation is 120-400 lines.

Test Plan:
- Single source: reset, then requester 0 sends message A at cycle 5 with lce_req_ready_i=1.
  - lce_req_v_o=1 with A and grant=0 at cycle 6.
  - count_r[0]=1 and credits_empty_o[0]=0 from cycle 6.
  - ready_o[0] is back to 1 at cycle 7.
- Round-robin fairness: num_lce_p=2, both requesters keep buffers full continuously with ready_i=1.
  - Grants alternate 0,1,0,1 after reset.
  - Over 20 sends each requester gets exactly 10.
- Backpressure: both buffers full and lce_req_ready_i=0 for 4 cycles.
  - lce_req_v_o=0 throughout, rr_r unchanged, both ready_o=0.
  - When ready_i returns to 1, requester rr_r is sent first.
- Credit exhaustion: credits_p=2; requester 1 issues 2 requests with no completion.
  - ready_o[1]=0 after the 2nd accept, and further v_i is ignored.
  - A req_complete_i[1] pulse at cycle t gives ready_o[1]=1 at t+1 with count_r[1]=1.
- Simultaneous events and underflow:
  - count_r[0]=1, accept and complete in the same cycle -> count_r[0] stays 1.
  - req_complete_i[1] with count_r[1]=0 -> underflow_o=1 sticky and count_r[1] stays 0.
- Async reset mid-operation: drop reset_n_i between clock edges while buf_v_r=2'b11 and count_r={3,2}.
  - Immediately (no clock edge): lce_req_v_o=0, all ready_o=1, credits_empty_o=2'b11.
  - After release, no stale message is emitted.

Source files
------------

// File: rtl/bp_lce_req_arbiter_if.sv
// Handshake bundle between the LCE request handlers and the shared request-port arbiter.
// The master modport is the requester/network side; the slave modport is the arbiter.
interface bp_lce_req_arbiter_if #(
    parameter int num_lce_p   = 2,
    parameter int msg_width_p = 128
) ();
    localparam int lg_num_lce_lp = (num_lce_p == 1) ? 1 : $clog2(num_lce_p);

    logic [num_lce_p*msg_width_p-1:0] lce_req_i;
    logic [num_lce_p-1:0]             lce_req_v_i;
    logic [num_lce_p-1:0]             lce_req_ready_o;
    logic [num_lce_p-1:0]             req_complete_i;
    logic [msg_width_p-1:0]           lce_req_o;
    logic                             lce_req_v_o;
    logic                             lce_req_ready_i;
    logic [lg_num_lce_lp-1:0]         lce_req_grant_o;
    logic [num_lce_p-1:0]             credits_empty_o;
    logic                             underflow_o;

    modport master (
        output lce_req_i, lce_req_v_i, req_complete_i, lce_req_ready_i,
        input  lce_req_ready_o, lce_req_o, lce_req_v_o, lce_req_grant_o,
               credits_empty_o, underflow_o
    );

    modport slave (
        input  lce_req_i, lce_req_v_i, req_complete_i, lce_req_ready_i,
        output lce_req_ready_o, lce_req_o, lce_req_v_o, lce_req_grant_o,
               credits_empty_o, underflow_o
    );
endinterface

// File: rtl/bp_lce_req_arbiter.sv
// Round-robin share of one LCE request port among num_lce_p requesters, each with a
// one-entry buffer and an outstanding-request credit counter.
module bp_lce_req_arbiter #(
    parameter int num_lce_p   = 2,
    parameter int msg_width_p = 128,
    parameter int credits_p   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_lce_req_arbiter_if.slave    lce_if
);
    localparam int lg_num_lce_lp = (num_lce_p == 1) ? 1 : $clog2(num_lce_p);
    localparam int cnt_w_lp      = $clog2(credits_p + 1);

    logic [msg_width_p-1:0]   r_buf   [num_lce_p];
    logic [num_lce_p-1:0]     r_buf_v;
    logic [cnt_w_lp-1:0]      r_count [num_lce_p];
    logic [lg_num_lce_lp-1:0] r_rr;
    logic                     r_underflow;

    logic [num_lce_p-1:0]     w_ready;
    logic [num_lce_p-1:0]     w_accept;
    logic [num_lce_p-1:0]     w_deq;
    logic [num_lce_p-1:0]     w_empty;
    logic [num_lce_p-1:0]     w_uf;
    logic [lg_num_lce_lp-1:0] w_grant;
    logic [lg_num_lce_lp-1:0] w_rr_next;
    logic                     w_send;

    // Per-requester ready, accept, credit-empty and underflow detection.
    always_comb begin
        w_ready  = '0;
        w_accept = '0;
        w_empty  = '0;
        w_uf     = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            w_ready[i]  = ~r_buf_v[i] & (r_count[i] < cnt_w_lp'(credits_p));
            w_accept[i] = lce_if.lce_req_v_i[i] & w_ready[i];
            w_empty[i]  = (r_count[i] == '0);
            w_uf[i]     = lce_if.req_complete_i[i] & w_empty[i] & ~w_accept[i];
        end
    end

    // Round-robin grant: first valid buffer at or after r_rr, wrapping.
    always_comb begin
        logic                     found;
        logic [lg_num_lce_lp-1:0] idx;
        w_grant = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < num_lce_p; k++) begin
            idx = lg_num_lce_lp'((int'(r_rr) + k) % num_lce_p);
            if (!found && r_buf_v[idx]) begin
                w_grant = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    end

    // Outbound send, dequeue one-hot and next rr pointer.
    always_comb begin
        w_send    = lce_if.lce_req_ready_i & (|r_buf_v);
        w_deq     = '0;
        w_rr_next = r_rr;
        if (w_send) begin
            w_deq[w_grant] = 1'b1;
            if (w_grant == lg_num_lce_lp'(num_lce_p - 1)) begin
                w_rr_next = '0;
            end else begin
                w_rr_next = w_grant + lg_num_lce_lp'(1);
            end
        end else begin
            w_rr_next = r_rr;
        end
    end

    // Buffers, credit counters, rr pointer and sticky underflow flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                r_buf[i]   <= '0;
                r_count[i] <= '0;
            end
            r_buf_v     <= '0;
            r_rr        <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < num_lce_p; i++) begin
                if (w_accept[i]) begin
                    r_buf[i]   <= lce_if.lce_req_i[i*msg_width_p +: msg_width_p];
                    r_buf_v[i] <= 1'b1;
                end else if (w_deq[i]) begin
                    r_buf_v[i] <= 1'b0;
                end else begin
                    r_buf_v[i] <= r_buf_v[i];
                end
                // Accept and completion in one cycle cancel; completion at zero saturates.
                case ({w_accept[i], lce_if.req_complete_i[i]})
                    2'b10:   r_count[i] <= r_count[i] + cnt_w_lp'(1);
                    2'b01:   r_count[i] <= w_empty[i] ? r_count[i] : r_count[i] - cnt_w_lp'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
            r_rr        <= w_rr_next;
            r_underflow <= r_underflow | (|w_uf);
        end
    end

    assign lce_if.lce_req_ready_o = w_ready;
    assign lce_if.lce_req_v_o     = w_send;
    assign lce_if.lce_req_o       = r_buf[w_grant];
    assign lce_if.lce_req_grant_o = w_grant;
    assign lce_if.credits_empty_o = w_empty;
    assign lce_if.underflow_o     = r_underflow;
endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Directed bench for bp_lce_req_arbiter: main instance with 8 credits and a second
// instance with 2 credits for the credit-exhaustion scenario.
module tb_bp_lce_req_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bp_lce_req_arbiter_if #(.num_lce_p(2), .msg_width_p(128)) bus  ();
    bp_lce_req_arbiter_if #(.num_lce_p(2), .msg_width_p(128)) bus2 ();

    bp_lce_req_arbiter #(.num_lce_p(2), .msg_width_p(128), .credits_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .lce_if    (bus.slave)
    );

    bp_lce_req_arbiter #(.num_lce_p(2), .msg_width_p(128), .credits_p(2)) dut2 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .lce_if    (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] MSG_A = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] MSG_P = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] MSG_Q = 128'hCAFE_F00D_6666_7777_8888_9999_AAAA_BBBB;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lce_req_i        = '0;
        bus.lce_req_v_i      = 2'b00;
        bus.req_complete_i   = 2'b00;
        bus.lce_req_ready_i  = 1'b1;
        bus2.lce_req_i       = '0;
        bus2.lce_req_v_i     = 2'b00;
        bus2.req_complete_i  = 2'b00;
        bus2.lce_req_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        tick();
        n_checks++; if (bus.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b expected 0", bus.lce_req_v_o); end
        n_checks++; if (bus.lce_req_ready_o !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b expected 11", bus.lce_req_ready_o); end
        n_checks++; if (bus.credits_empty_o !== 2'b11) begin n_fail++; $display("FAIL reset_cempty: got %b expected 11", bus.credits_empty_o); end
        n_checks++; if (bus.lce_req_grant_o !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", bus.lce_req_grant_o); end
        n_checks++; if (bus.lce_req_o !== 128'd0) begin n_fail++; $display("FAIL reset_msg: got %h expected 0", bus.lce_req_o); end
        n_checks++; if (bus.underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b expected 0", bus.underflow_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_source();
        bus.lce_req_i[127:0] = MSG_A;
        bus.lce_req_v_i      = 2'b01;
        tick();
        bus.lce_req_v_i = 2'b00;
        n_checks++; if (bus.lce_req_v_o !== 1'b1) begin n_fail++; $display("FAIL single_v_o: got %b expected 1", bus.lce_req_v_o); end
        n_checks++; if (bus.lce_req_o !== MSG_A) begin n_fail++; $display("FAIL single_msg: got %h expected %h", bus.lce_req_o, MSG_A); end
        n_checks++; if (bus.lce_req_grant_o !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %b expected 0", bus.lce_req_grant_o); end
        n_checks++; if (bus.credits_empty_o !== 2'b10) begin n_fail++; $display("FAIL single_cempty: got %b expected 10", bus.credits_empty_o); end
        n_checks++; if (dut.r_count[0] !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", dut.r_count[0]); end
        n_checks++; if (bus.lce_req_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b expected 0", bus.lce_req_ready_o[0]); end
        tick();
        n_checks++; if (bus.lce_req_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b expected 1", bus.lce_req_ready_o[0]); end
        n_checks++; if (bus.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_v_o: got %b expected 0", bus.lce_req_v_o); end
    endtask

    task automatic test_round_robin();
        int cnt0;
        int cnt1;
        cnt0 = 0;
        cnt1 = 0;
        bus.lce_req_i   = {MSG_Q, MSG_P};
        bus.lce_req_v_i = 2'b11;
        tick();
        for (int k = 0; k < 20; k++) begin
            bus.lce_req_v_i    = bus.lce_req_ready_o;
            bus.req_complete_i = bus.lce_req_v_o ? (2'b01 << bus.lce_req_grant_o) : 2'b00;
            n_checks++; if (bus.lce_req_v_o !== 1'b1) begin n_fail++; $display("FAIL rr_v_o[%0d]: got %b expected 1", k, bus.lce_req_v_o); end
            n_checks++; if (bus.lce_req_grant_o !== 1'(k % 2)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %0d", k, bus.lce_req_grant_o, k % 2); end
            if (bus.lce_req_v_o === 1'b1 && bus.lce_req_grant_o === 1'b0) cnt0++;
            else if (bus.lce_req_v_o === 1'b1 && bus.lce_req_grant_o === 1'b1) cnt1++;
            tick();
        end
        bus.lce_req_v_i    = 2'b00;
        bus.req_complete_i = 2'b00;
        n_checks++; if (cnt0 !== 10) begin n_fail++; $display("FAIL rr_count0: got %0d expected 10", cnt0); end
        n_checks++; if (cnt1 !== 10) begin n_fail++; $display("FAIL rr_count1: got %0d expected 10", cnt1); end
    endtask

    task automatic test_backpressure();
        bus.lce_req_i[127:0] = MSG_A;
        bus.lce_req_v_i      = 2'b01;
        tick();
        bus.lce_req_v_i = 2'b00;
        tick();
        bus.lce_req_ready_i = 1'b0;
        bus.lce_req_i       = {MSG_Q, MSG_P};
        bus.lce_req_v_i     = 2'b11;
        tick();
        bus.lce_req_v_i = 2'b00;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL bp_v_o[%0d]: got %b expected 0", k, bus.lce_req_v_o); end
            n_checks++; if (bus.lce_req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, bus.lce_req_ready_o); end
            n_checks++; if (dut.r_rr !== 1'b1) begin n_fail++; $display("FAIL bp_rr[%0d]: got %b expected 1", k, dut.r_rr); end
            tick();
        end
        bus.lce_req_ready_i = 1'b1;
        #1;
        n_checks++; if (bus.lce_req_grant_o !== 1'b1) begin n_fail++; $display("FAIL bp_first_grant: got %b expected 1", bus.lce_req_grant_o); end
        n_checks++; if (bus.lce_req_o !== MSG_Q) begin n_fail++; $display("FAIL bp_first_msg: got %h expected %h", bus.lce_req_o, MSG_Q); end
        tick();
        n_checks++; if (bus.lce_req_grant_o !== 1'b0) begin n_fail++; $display("FAIL bp_second_grant: got %b expected 0", bus.lce_req_grant_o); end
        n_checks++; if (bus.lce_req_o !== MSG_P) begin n_fail++; $display("FAIL bp_second_msg: got %h expected %h", bus.lce_req_o, MSG_P); end
        tick();
    endtask

    task automatic test_credit_exhaustion();
        bus2.lce_req_i[255:128] = MSG_Q;
        bus2.lce_req_v_i = 2'b10; tick();
        bus2.lce_req_v_i = 2'b00; tick();
        bus2.lce_req_v_i = 2'b10; tick();
        bus2.lce_req_v_i = 2'b00; tick();
        n_checks++; if (bus2.lce_req_ready_o[1] !== 1'b0) begin n_fail++; $display("FAIL cred_ready_exhausted: got %b expected 0", bus2.lce_req_ready_o[1]); end
        n_checks++; if (dut2.r_count[1] !== 2'd2) begin n_fail++; $display("FAIL cred_count_full: got %0d expected 2", dut2.r_count[1]); end
        bus2.lce_req_v_i = 2'b10; tick();
        bus2.lce_req_v_i = 2'b00;
        n_checks++; if (bus2.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL cred_ignored_v_o: got %b expected 0", bus2.lce_req_v_o); end
        n_checks++; if (dut2.r_count[1] !== 2'd2) begin n_fail++; $display("FAIL cred_ignored_count: got %0d expected 2", dut2.r_count[1]); end
        bus2.req_complete_i = 2'b10; tick();
        bus2.req_complete_i = 2'b00;
        n_checks++; if (bus2.lce_req_ready_o[1] !== 1'b1) begin n_fail++; $display("FAIL cred_ready_return: got %b expected 1", bus2.lce_req_ready_o[1]); end
        n_checks++; if (dut2.r_count[1] !== 2'd1) begin n_fail++; $display("FAIL cred_count_return: got %0d expected 1", dut2.r_count[1]); end
    endtask

    task automatic test_simultaneous_underflow();
        bus.lce_req_i[127:0] = MSG_A;
        bus.lce_req_v_i = 2'b01; tick();
        bus.lce_req_v_i = 2'b00; tick();
        bus.lce_req_v_i    = 2'b01;
        bus.req_complete_i = 2'b01;
        tick();
        bus.lce_req_v_i    = 2'b00;
        bus.req_complete_i = 2'b00;
        n_checks++; if (dut.r_count[0] !== 4'd1) begin n_fail++; $display("FAIL simul_count: got %0d expected 1", dut.r_count[0]); end
        n_checks++; if (bus.credits_empty_o[0] !== 1'b0) begin n_fail++; $display("FAIL simul_cempty: got %b expected 0", bus.credits_empty_o[0]); end
        bus.req_complete_i = 2'b10; tick();
        bus.req_complete_i = 2'b00;
        n_checks++; if (bus.underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b expected 1", bus.underflow_o); end
        n_checks++; if (dut.r_count[1] !== 4'd0) begin n_fail++; $display("FAIL uf_count: got %0d expected 0", dut.r_count[1]); end
        n_checks++; if (bus.credits_empty_o[1] !== 1'b1) begin n_fail++; $display("FAIL uf_cempty: got %b expected 1", bus.credits_empty_o[1]); end
        tick();
        n_checks++; if (bus.underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b expected 1", bus.underflow_o); end
    endtask

    task automatic test_async_reset();
        bus.lce_req_i = {MSG_Q, MSG_P};
        bus.lce_req_v_i = 2'b11; tick();
        bus.lce_req_v_i = 2'b00; tick();
        bus.lce_req_v_i = 2'b01; tick();
        bus.lce_req_v_i = 2'b10; bus.req_complete_i = 2'b01; tick();
        bus.req_complete_i = 2'b00;
        bus.lce_req_v_i = 2'b01; tick();
        bus.lce_req_ready_i = 1'b0;
        bus.lce_req_v_i = 2'b10; tick();
        bus.lce_req_v_i = 2'b00;
        n_checks++; if (bus.lce_req_ready_o !== 2'b00) begin n_fail++; $display("FAIL ar_pre_ready: got %b expected 00", bus.lce_req_ready_o); end
        n_checks++; if (dut.r_count[1] !== 4'd3 || dut.r_count[0] !== 4'd2) begin n_fail++; $display("FAIL ar_pre_count: got %0d,%0d expected 3,2", dut.r_count[1], dut.r_count[0]); end
        #2;
        bus.lce_req_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL ar_v_o: got %b expected 0", bus.lce_req_v_o); end
        n_checks++; if (bus.lce_req_ready_o !== 2'b11) begin n_fail++; $display("FAIL ar_ready: got %b expected 11", bus.lce_req_ready_o); end
        n_checks++; if (bus.credits_empty_o !== 2'b11) begin n_fail++; $display("FAIL ar_cempty: got %b expected 11", bus.credits_empty_o); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (bus.lce_req_v_o !== 1'b0) begin n_fail++; $display("FAIL ar_stale[%0d]: got %b expected 0", k, bus.lce_req_v_o); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        clear_inputs();
        test_reset();
        test_single_source();
        test_reset();
        test_round_robin();
        test_reset();
        test_backpressure();
        test_reset();
        test_credit_exhaustion();
        test_reset();
        test_simultaneous_underflow();
        test_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
